// File: rtl/vx_vgpr_responder.sv
// Vector GPR file responder: serves operand reads with a fixed 2-cycle latency,
// accepts masked writeback, bounds read starvation and zero-fills itself after reset.
module vx_vgpr_responder #(
  parameter int SIMD_WIDTH    = 4,
  parameter int XLEN          = 32,
  parameter int ISSUE_WIS     = 4,
  parameter int SIMD_COUNT    = 2,
  parameter int VL_COUNT      = 4,
  parameter int NUM_REGS      = 32,
  parameter int SRC_OPD_WIDTH = 2,
  parameter int WB_BURST_MAX  = 4,
  localparam int ISSUE_WIS_W  = (ISSUE_WIS > 1) ? $clog2(ISSUE_WIS) : 1,
  localparam int SIMD_IDX_W   = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1,
  localparam int VL_WIDTH     = (VL_COUNT > 1) ? $clog2(VL_COUNT) : 1,
  localparam int RV_REGS_BITS = $clog2(NUM_REGS),
  localparam int ROW_W        = SIMD_WIDTH * XLEN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [SRC_OPD_WIDTH-1:0] req_opd_id,
  input  logic [VL_WIDTH-1:0]      req_lid,
  input  logic [ISSUE_WIS_W-1:0]   req_wis,
  input  logic [SIMD_IDX_W-1:0]    req_sid,
  input  logic [RV_REGS_BITS-1:0]  req_reg_id,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [SRC_OPD_WIDTH-1:0] rsp_opd_id,
  output logic [ROW_W-1:0]         rsp_data,
  input  logic                     wb_valid,
  input  logic [ISSUE_WIS_W-1:0]   wb_wis,
  input  logic [SIMD_IDX_W-1:0]    wb_sid,
  input  logic [VL_WIDTH-1:0]      wb_lid,
  input  logic [RV_REGS_BITS-1:0]  wb_reg_id,
  input  logic [SIMD_WIDTH-1:0]    wb_mask,
  input  logic [ROW_W-1:0]         wb_data,
  output logic                     wb_ready
);

  localparam int ADDR_W = ISSUE_WIS_W + SIMD_IDX_W + VL_WIDTH + RV_REGS_BITS;
  localparam int DEPTH  = ISSUE_WIS * SIMD_COUNT * VL_COUNT * NUM_REGS;
  localparam int WCNT_W = $clog2(WB_BURST_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WCNT_W-1:0] WB_MAX_C  = WCNT_W'(WB_BURST_MAX);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   init_cnt_reg, init_cnt_next;
  logic [WCNT_W-1:0]   wcnt_reg, wcnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
      wcnt_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      wcnt_reg     <= wcnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    wcnt_next     = wcnt_reg;
    req_ready     = 1'b0;
    wb_ready      = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == LAST_ADDR) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Writes win until WB_BURST_MAX grants have gone by with a read waiting.
        if (wb_valid && (wcnt_reg < WB_MAX_C || !req_valid)) begin
          wb_ready = 1'b1;
        end else begin
          req_ready = 1'b1;
          wb_ready  = !wb_valid;
        end
        if (!req_valid || req_ready) wcnt_next = '0;
        else if (wb_valid && wb_ready && wcnt_reg < WB_MAX_C) wcnt_next = wcnt_reg + 1'b1;
      end
    endcase
  end

  logic              req_fire, wb_fire, mem_init, mem_wr_row;
  logic [ADDR_W-1:0] req_addr, wb_addr, mem_waddr;
  logic [ROW_W-1:0]  s1_row;

  assign req_fire   = req_valid && req_ready;
  assign wb_fire    = wb_valid && wb_ready;
  assign req_addr   = {req_wis, req_sid, req_lid, req_reg_id};
  assign wb_addr    = {wb_wis, wb_sid, wb_lid, wb_reg_id};
  assign mem_init   = (state_reg == ST_INIT);
  assign mem_waddr  = mem_init ? init_cnt_reg : wb_addr;
  assign mem_wr_row = mem_init || (wb_fire && (wb_reg_id != '0));

  logic                     s0_valid_reg, s1_valid_reg;
  logic [SRC_OPD_WIDTH-1:0] s0_opd_reg, s1_opd_reg;
  logic [ADDR_W-1:0]        s0_addr_reg;
  logic                     s0_zero_reg, s1_zero_reg;

  // One RAM per lane so the lane mask maps onto independent write enables.
  genvar gi;
  generate
    for (gi = 0; gi < SIMD_WIDTH; gi++) begin : g_lane
      logic [XLEN-1:0] lane_mem [DEPTH];
      logic [XLEN-1:0] rd_lane_reg;
      always_ff @(posedge clk) begin
        if (mem_wr_row && (mem_init || wb_mask[gi]))
          lane_mem[mem_waddr] <= mem_init ? '0 : wb_data[gi*XLEN +: XLEN];
        rd_lane_reg <= lane_mem[s0_addr_reg];
      end
      assign s1_row[gi*XLEN +: XLEN] = rd_lane_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_reg <= 1'b0;
      s0_opd_reg   <= '0;
      s0_addr_reg  <= '0;
      s0_zero_reg  <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_opd_reg   <= '0;
      s1_zero_reg  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_opd_id   <= '0;
      rsp_data     <= '0;
    end else begin
      s0_valid_reg <= req_fire;
      if (req_fire) begin
        s0_opd_reg  <= req_opd_id;
        s0_addr_reg <= req_addr;
        s0_zero_reg <= (req_reg_id == '0);
      end
      s1_valid_reg <= s0_valid_reg;
      s1_opd_reg   <= s0_opd_reg;
      s1_zero_reg  <= s0_zero_reg;
      rsp_valid    <= s1_valid_reg;
      if (s1_valid_reg) begin
        rsp_opd_id <= s1_opd_reg;
        rsp_data   <= s1_zero_reg ? '0 : s1_row;
      end
    end
  end

endmodule

// File: tb/tb_vx_vgpr_responder.sv
// Directed bench for vx_vgpr_responder: a row model feeds an expected-response
// queue that a negedge monitor drains, checking tag, data and latency.
module tb_vx_vgpr_responder;

  logic         clk, reset_n;
  logic         req_valid, req_ready, rsp_valid, wb_valid, wb_ready;
  logic [1:0]   req_opd_id, rsp_opd_id, req_lid, req_wis, wb_wis, wb_lid;
  logic         req_sid, wb_sid;
  logic [4:0]   req_reg_id, wb_reg_id;
  logic [3:0]   wb_mask;
  logic [127:0] rsp_data, wb_data;

  vx_vgpr_responder dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_opd_id(req_opd_id), .req_lid(req_lid),
    .req_wis(req_wis), .req_sid(req_sid), .req_reg_id(req_reg_id), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_opd_id(rsp_opd_id), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_sid(wb_sid), .wb_lid(wb_lid),
    .wb_reg_id(wb_reg_id), .wb_mask(wb_mask), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   opd;
    logic [127:0] data;
    int           due;
  } exp_t;
  exp_t sb[$];

  logic [127:0] model [1024];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 1024; k++) model[k] = '0;
  endtask

  // Observe the handshake just after the driving edge, then advance one cycle.
  task automatic tick(output logic rf, output logic wf);
    exp_t e;
    logic [9:0] a;
    #1;
    rf = req_valid && req_ready;
    wf = wb_valid && wb_ready;
    if (wf && wb_reg_id != 5'd0) begin
      a = {wb_wis, wb_sid, wb_lid, wb_reg_id};
      for (int i = 0; i < 4; i++)
        if (wb_mask[i]) model[a][i*32 +: 32] = wb_data[i*32 +: 32];
    end
    if (rf) begin
      a = {req_wis, req_sid, req_lid, req_reg_id};
      e.opd  = req_opd_id;
      e.data = (req_reg_id == 5'd0) ? 128'd0 : model[a];
      e.due  = edge_cnt + 3;
      sb.push_back(e);
      $display("read  accepted opd=%0d addr=%0h due_edge=%0d", e.opd, a, e.due);
    end
    if (wf) $display("write granted  reg=%0d mask=%b", wb_reg_id, wb_mask);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL rsp_unexpected observed=response opd=%0d expected=no response", rsp_opd_id);
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("response       opd=%0d data=%0h", rsp_opd_id, rsp_data);
        check("rsp_opd_id", {126'd0, rsp_opd_id}, {126'd0, e.opd});
        check("rsp_data", rsp_data, e.data);
        check("rsp_latency", edge_cnt, e.due);
      end
    end
  end

  initial begin
    logic rf, wf;
    int n;
    clear_model();
    reset_n = 1'b0; req_valid = 1'b0; wb_valid = 1'b0;
    req_opd_id = '0; req_lid = '0; req_wis = '0; req_sid = '0; req_reg_id = '0;
    wb_wis = '0; wb_sid = '0; wb_lid = '0; wb_reg_id = '0; wb_mask = '0; wb_data = '0;
    repeat (3) @(negedge clk);

    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_opd_id", rsp_opd_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_wb_ready", wb_ready, 0);

    // Init sweep: a waiting read must be held off for exactly DEPTH cycles.
    reset_n = 1'b1;
    req_valid = 1'b1; req_wis = 2'd1; req_sid = 1'b0; req_lid = 2'd2; req_reg_id = 5'd5; req_opd_id = 2'd1;
    n = 0; rf = 1'b0;
    while (!rf && n < 2000) begin
      tick(rf, wf);
      if (!rf) n++;
    end
    check("init_hold_cycles", n, 1024);
    req_valid = 1'b0;
    repeat (4) tick(rf, wf);

    // Masked writeback then read-back.
    wb_valid = 1'b1; wb_wis = 2'd0; wb_sid = 1'b1; wb_lid = 2'd3; wb_reg_id = 5'd7;
    wb_mask = 4'b1111; wb_data = {32'h44, 32'h33, 32'h22, 32'h11};
    tick(rf, wf);
    check("wb_grant_full", wf, 1);
    wb_mask = 4'b0100; wb_data = {32'hFFFF_FFFF, 32'hAA, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tick(rf, wf);
    check("wb_grant_masked", wf, 1);
    wb_valid = 1'b0;
    req_valid = 1'b1; req_wis = 2'd0; req_sid = 1'b1; req_lid = 2'd3; req_reg_id = 5'd7; req_opd_id = 2'd2;
    tick(rf, wf);
    check("read_masked_grant", rf, 1);
    check("model_masked_row", model[{2'd0, 1'b1, 2'd3, 5'd7}], {32'h44, 32'hAA, 32'h22, 32'h11});
    req_valid = 1'b0;
    repeat (4) tick(rf, wf);

    // Register zero: write accepted but never observable.
    wb_valid = 1'b1; wb_wis = 2'd2; wb_sid = 1'b1; wb_lid = 2'd1; wb_reg_id = 5'd0;
    wb_mask = 4'b1111; wb_data = {4{32'hDEAD_BEEF}};
    tick(rf, wf);
    check("wb_reg0_ready", wf, 1);
    wb_valid = 1'b0;
    req_valid = 1'b1; req_wis = 2'd2; req_sid = 1'b1; req_lid = 2'd1; req_reg_id = 5'd0; req_opd_id = 2'd0;
    tick(rf, wf);
    check("read_reg0_grant", rf, 1);
    req_valid = 1'b0;
    repeat (4) tick(rf, wf);

    // Contention: four write grants then one read grant, repeating.
    for (int i = 0; i < 20; i++) begin
      wb_valid = 1'b1; wb_wis = 2'd3; wb_sid = 1'b0; wb_lid = 2'd1; wb_reg_id = 5'(8 + i % 4);
      wb_mask = 4'($urandom_range(1, 15));
      wb_data = {$urandom, $urandom, $urandom, $urandom};
      req_valid = 1'b1; req_wis = 2'd3; req_sid = 1'b0; req_lid = 2'd1;
      req_reg_id = 5'(8 + (i + 3) % 4); req_opd_id = 2'(i % 4);
      tick(rf, wf);
      check($sformatf("arb_read_%0d", i), rf, (i % 5 == 4));
      check($sformatf("arb_write_%0d", i), wf, (i % 5 != 4));
    end
    wb_valid = 1'b0;

    // Back-to-back reads must stream out back-to-back.
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_reg_id = 5'(8 + i); req_opd_id = 2'(i);
      tick(rf, wf);
      check($sformatf("b2b_grant_%0d", i), rf, 1);
    end
    req_valid = 1'b0;
    repeat (5) tick(rf, wf);

    // Reset with a read in flight: response dropped, storage re-zeroed.
    wb_valid = 1'b1; wb_wis = 2'd0; wb_sid = 1'b0; wb_lid = 2'd0; wb_reg_id = 5'd20;
    wb_mask = 4'b1111; wb_data = {$urandom, $urandom, $urandom, 32'h1234_5678};
    tick(rf, wf);
    check("wb_before_reset", wf, 1);
    wb_valid = 1'b0;
    req_valid = 1'b1; req_wis = 2'd0; req_sid = 1'b0; req_lid = 2'd0; req_reg_id = 5'd20; req_opd_id = 2'd3;
    tick(rf, wf);
    check("read_before_reset", rf, 1);
    reset_n = 1'b0; req_valid = 1'b0;
    sb.delete();
    clear_model();
    #1;
    check("midreset_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 1'b1; req_opd_id = 2'd1;
    n = 0; rf = 1'b0;
    while (!rf && n < 2000) begin
      tick(rf, wf);
      if (!rf) n++;
    end
    check("reinit_hold_cycles", n, 1024);
    req_valid = 1'b0;
    repeat (6) tick(rf, wf);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
